bunch_strobe_sequencer: RTL and testbench

//  Run-time programmable scheduler for the multi-bunch sampling strobe. Host loads a

---
 rtl/bunch_strobe_sequencer_if.sv | 31 +++
 rtl/bunch_strobe_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_bunch_strobe_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/bunch_strobe_sequencer_if.sv
// Host/sequencer bus for bunch_strobe_sequencer: staging config, control
// pulses and the registered strobe/status outputs.
interface bunch_strobe_sequencer_if #(
  parameter int unsigned CW = 11
);
  logic          cfg_wr;
  logic [9:0]    cfg_first;
  logic [4:0]    cfg_nbunch;
  logic [7:0]    cfg_nsamp;
  logic [CW-1:0] cfg_spacing;
  logic          arm;
  logic          trig;
  logic          abort;
  logic          store_strb;
  logic          bunch_strb;
  logic [4:0]    bunch_idx;
  logic          busy;
  logic          done;
  logic          cfg_err;
  logic          overrun;

  modport master (
    output cfg_wr, cfg_first, cfg_nbunch, cfg_nsamp, cfg_spacing, arm, trig, abort,
    input  store_strb, bunch_strb, bunch_idx, busy, done, cfg_err, overrun
  );

  modport slave (
    input  cfg_wr, cfg_first, cfg_nbunch, cfg_nsamp, cfg_spacing, arm, trig, abort,
    output store_strb, bunch_strb, bunch_idx, busy, done, cfg_err, overrun
  );
endinterface

// File: rtl/bunch_strobe_sequencer.sv
// Run-time programmable multi-bunch strobe scheduler.
// Optional feature: define SEQ_RUN_COUNT_EN to add the run_count[15:0] output
// (counts done pulses, wraps, cleared by rst only).
module bunch_strobe_sequencer #(
  parameter int unsigned STORE_LEN = 1500,
  parameter int unsigned CW        = 11
) (
  input logic clk,
  input logic rst,
  bunch_strobe_sequencer_if.slave bus
`ifdef SEQ_RUN_COUNT_EN
  ,
  output logic [15:0] run_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [9:0]    stg_first_q, stg_first_d;
  logic [4:0]    stg_nbunch_q, stg_nbunch_d;
  logic [7:0]    stg_nsamp_q, stg_nsamp_d;
  logic [CW-1:0] stg_spacing_q, stg_spacing_d;
  logic [4:0]    act_nbunch_q, act_nbunch_d;
  logic [7:0]    act_nsamp_q, act_nsamp_d;
  logic [CW-1:0] act_spacing_q, act_spacing_d;
  logic [CW-1:0] i_q, i_d;
  logic [11:0]   start_q, start_d;
  logic [4:0]    k_q, k_d;
  logic [7:0]    rem_q, rem_d;
  logic [4:0]    cmpl_q, cmpl_d;
  logic          ovf_q, ovf_d;
  logic          store_strb_q, store_strb_d;
  logic          bunch_strb_q, bunch_strb_d;
  logic [4:0]    bunch_idx_q, bunch_idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cfg_err_q, cfg_err_d;
  logic          overrun_q, overrun_d;
`ifdef SEQ_RUN_COUNT_EN
  logic [15:0]   run_count_q, run_count_d;
`endif

  logic [4:0]    sel_nb, sel_k;
  logic [7:0]    sel_ns;
  logic [CW-1:0] sel_sp;
  logic [11:0]   sel_start, sel_n, next_start;
  logic          hit, stg_bad, accept, win_end;

  // Next-state logic; the bunch-start test is shared between the trigger
  // cycle (staging config, window index 0) and the run (active config, i+1).
  always_comb begin
    state_d       = state_q;
    stg_first_d   = stg_first_q;
    stg_nbunch_d  = stg_nbunch_q;
    stg_nsamp_d   = stg_nsamp_q;
    stg_spacing_d = stg_spacing_q;
    act_nbunch_d  = act_nbunch_q;
    act_nsamp_d   = act_nsamp_q;
    act_spacing_d = act_spacing_q;
    i_d           = i_q;
    start_d       = start_q;
    k_d           = k_q;
    rem_d         = rem_q;
    cmpl_d        = cmpl_q;
    ovf_d         = ovf_q;
    store_strb_d  = store_strb_q;
    bunch_strb_d  = bunch_strb_q;
    bunch_idx_d   = bunch_idx_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    cfg_err_d     = 1'b0;
    overrun_d     = overrun_q;

    if (bus.cfg_wr) begin
      stg_first_d   = bus.cfg_first;
      stg_nbunch_d  = bus.cfg_nbunch;
      stg_nsamp_d   = bus.cfg_nsamp;
      stg_spacing_d = bus.cfg_spacing;
    end

    if (state_q == S_ARMED) begin
      sel_nb    = stg_nbunch_q;
      sel_ns    = stg_nsamp_q;
      sel_sp    = stg_spacing_q;
      sel_start = {2'b00, stg_first_q};
      sel_k     = '0;
      sel_n     = '0;
    end else begin
      sel_nb    = act_nbunch_q;
      sel_ns    = act_nsamp_q;
      sel_sp    = act_spacing_q;
      sel_start = start_q;
      sel_k     = k_q;
      sel_n     = 12'(i_q) + 12'd1;
    end
    next_start = sel_start + 12'(sel_sp);
    hit        = (sel_k < sel_nb) && (sel_start == sel_n);
    stg_bad    = (stg_nbunch_q == '0) || (stg_nsamp_q == '0) ||
                 (stg_spacing_q <= CW'(stg_nsamp_q));
    accept     = (state_q == S_ARMED) && bus.trig && !stg_bad;
    win_end    = (state_q == S_RUN) && (i_q == CW'(STORE_LEN - 1));

    case (state_q)
      S_IDLE: begin
        if (bus.arm) begin
          state_d = S_ARMED;
          busy_d  = 1'b1;
        end
      end
      S_ARMED: begin
        if (bus.trig) begin
          if (stg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            act_nbunch_d  = stg_nbunch_q;
            act_nsamp_d   = stg_nsamp_q;
            act_spacing_d = stg_spacing_q;
            overrun_d     = 1'b0;
            state_d       = S_RUN;
            store_strb_d  = 1'b1;
            bunch_strb_d  = 1'b0;
            i_d           = '0;
            k_d           = '0;
            start_d       = sel_start;
            cmpl_d        = '0;
            ovf_d         = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (win_end) begin
          // A gate still open here is truncated and does not count as complete.
          state_d      = S_DONE;
          store_strb_d = 1'b0;
          bunch_strb_d = 1'b0;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          overrun_d    = ovf_q || (cmpl_q != act_nbunch_q);
        end else begin
          i_d = i_q + CW'(1);
          if (bunch_strb_q) begin
            if (rem_q == 8'd1) begin
              bunch_strb_d = 1'b0;
              cmpl_d       = cmpl_q + 5'd1;
            end else begin
              rem_d = rem_q - 8'd1;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if ((accept || ((state_q == S_RUN) && !win_end)) && hit) begin
      bunch_strb_d = 1'b1;
      rem_d        = sel_ns;
      bunch_idx_d  = sel_k;
      k_d          = sel_k + 5'd1;
      start_d      = next_start;
      if ((next_start > 12'd2047) && (({1'b0, sel_k} + 6'd1) < {1'b0, sel_nb}))
        ovf_d = 1'b1;
    end

    if (bus.abort) begin
      state_d      = S_IDLE;
      store_strb_d = 1'b0;
      bunch_strb_d = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      cfg_err_d    = 1'b0;
      overrun_d    = overrun_q;
    end

`ifdef SEQ_RUN_COUNT_EN
    run_count_d = done_d ? run_count_q + 16'd1 : run_count_q;
`endif
  end

  // State, configuration and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      stg_first_q   <= '0;
      stg_nbunch_q  <= '0;
      stg_nsamp_q   <= '0;
      stg_spacing_q <= '0;
      act_nbunch_q  <= '0;
      act_nsamp_q   <= '0;
      act_spacing_q <= '0;
      i_q           <= '0;
      start_q       <= '0;
      k_q           <= '0;
      rem_q         <= '0;
      cmpl_q        <= '0;
      ovf_q         <= 1'b0;
      store_strb_q  <= 1'b0;
      bunch_strb_q  <= 1'b0;
      bunch_idx_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef SEQ_RUN_COUNT_EN
      run_count_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      stg_first_q   <= stg_first_d;
      stg_nbunch_q  <= stg_nbunch_d;
      stg_nsamp_q   <= stg_nsamp_d;
      stg_spacing_q <= stg_spacing_d;
      act_nbunch_q  <= act_nbunch_d;
      act_nsamp_q   <= act_nsamp_d;
      act_spacing_q <= act_spacing_d;
      i_q           <= i_d;
      start_q       <= start_d;
      k_q           <= k_d;
      rem_q         <= rem_d;
      cmpl_q        <= cmpl_d;
      ovf_q         <= ovf_d;
      store_strb_q  <= store_strb_d;
      bunch_strb_q  <= bunch_strb_d;
      bunch_idx_q   <= bunch_idx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cfg_err_q     <= cfg_err_d;
      overrun_q     <= overrun_d;
`ifdef SEQ_RUN_COUNT_EN
      run_count_q   <= run_count_d;
`endif
    end
  end

  assign bus.store_strb = store_strb_q;
  assign bus.bunch_strb = bunch_strb_q;
  assign bus.bunch_idx  = bunch_idx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.overrun    = overrun_q;
`ifdef SEQ_RUN_COUNT_EN
  assign run_count      = run_count_q;
`endif

endmodule

// File: tb/tb_bunch_strobe_sequencer.sv
// Directed self-checking bench for bunch_strobe_sequencer (STORE_LEN=300).
module tb_bunch_strobe_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bunch_strobe_sequencer_if #(.CW(11)) bus();
`ifdef SEQ_RUN_COUNT_EN
  logic [15:0] run_count;
`endif

  bunch_strobe_sequencer #(.STORE_LEN(300), .CW(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SEQ_RUN_COUNT_EN
    ,
    .run_count (run_count)
`endif
  );

  int tests = 0;
  int fails = 0;
  logic st_a [0:319];
  logic bs_a [0:319];
  logic dn_a [0:319];
  int st_cnt, bs_cnt, dn_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int n);
    st_cnt = 0; bs_cnt = 0; dn_cnt = 0;
    for (int c = 0; c < n; c++) begin
      st_a[c] = bus.store_strb;
      bs_a[c] = bus.bunch_strb;
      dn_a[c] = bus.done;
      if (bus.store_strb === 1'b1) st_cnt++;
      if (bus.bunch_strb === 1'b1) bs_cnt++;
      if (bus.done === 1'b1) dn_cnt++;
      step();
    end
  endtask

  task automatic cfg(input logic [9:0] f, input logic [4:0] nb, input logic [7:0] ns,
                     input logic [10:0] sp);
    bus.cfg_first = f; bus.cfg_nbunch = nb; bus.cfg_nsamp = ns; bus.cfg_spacing = sp;
    bus.cfg_wr = 1'b1;
    step();
    bus.cfg_wr = 1'b0;
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1; step(); bus.arm = 1'b0;
  endtask

  task automatic pulse_trig();
    bus.trig = 1'b1; step(); bus.trig = 1'b0;
  endtask

  initial begin
    int dcount;
    bus.cfg_wr = 1'b0; bus.cfg_first = '0; bus.cfg_nbunch = '0; bus.cfg_nsamp = '0;
    bus.cfg_spacing = '0; bus.arm = 1'b0; bus.trig = 1'b0; bus.abort = 1'b0;
    rst = 1'b1;
    step(); step();
    chk("rst_store", bus.store_strb, 0);
    chk("rst_bunch", bus.bunch_strb, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_idx", bus.bunch_idx, 0);
    chk("rst_overrun", bus.overrun, 0);
    rst = 1'b0;
    step();

    // Test 1: two single-cycle gates at i=10 and i=110
    cfg(10'd10, 5'd2, 8'd1, 11'd100);
    pulse_arm();
    chk("t1_armed_busy", bus.busy, 1);
    chk("t1_armed_store", bus.store_strb, 0);
    pulse_trig();
    capture(320);
    chk("t1_store_first", st_a[0], 1);
    chk("t1_store_len", st_cnt, 300);
    chk("t1_store_off", st_a[300], 0);
    chk("t1_bunch_cnt", bs_cnt, 2);
    chk("t1_bunch_9", bs_a[9], 0);
    chk("t1_bunch_10", bs_a[10], 1);
    chk("t1_bunch_11", bs_a[11], 0);
    chk("t1_bunch_110", bs_a[110], 1);
    chk("t1_done_cnt", dn_cnt, 1);
    chk("t1_done_pos", dn_a[300], 1);
    chk("t1_done_early", dn_a[299], 0);
    chk("t1_overrun", bus.overrun, 0);
    chk("t1_idx", bus.bunch_idx, 1);
    chk("t1_busy_end", bus.busy, 0);

    // Test 2: trig while idle ignored; arm+trig together only arms
    pulse_trig();
    chk("t2_idle_trig_store", bus.store_strb, 0);
    chk("t2_idle_trig_busy", bus.busy, 0);
    bus.arm = 1'b1; bus.trig = 1'b1;
    step();
    bus.arm = 1'b0; bus.trig = 1'b0;
    chk("t2_armtrig_busy", bus.busy, 1);
    chk("t2_armtrig_store", bus.store_strb, 0);
    step();
    chk("t2_armtrig_store2", bus.store_strb, 0);

    // Test 3: spacing == nsamp rejected
    cfg(10'd0, 5'd1, 8'd5, 11'd5);
    pulse_trig();
    chk("t3_cfg_err", bus.cfg_err, 1);
    chk("t3_store", bus.store_strb, 0);
    chk("t3_busy", bus.busy, 1);
    step();
    chk("t3_cfg_err_pulse", bus.cfg_err, 0);
    chk("t3_still_busy", bus.busy, 1);

    // Test 4: last gate runs into window end -> overrun
    cfg(10'd250, 5'd3, 8'd10, 11'd20);
    pulse_trig();
    capture(320);
    chk("t4_store_len", st_cnt, 300);
    chk("t4_bunch_cnt", bs_cnt, 30);
    chk("t4_bunch_249", bs_a[249], 0);
    chk("t4_bunch_250", bs_a[250], 1);
    chk("t4_bunch_259", bs_a[259], 1);
    chk("t4_bunch_260", bs_a[260], 0);
    chk("t4_bunch_270", bs_a[270], 1);
    chk("t4_bunch_290", bs_a[290], 1);
    chk("t4_bunch_299", bs_a[299], 1);
    chk("t4_bunch_300", bs_a[300], 0);
    chk("t4_done_pos", dn_a[300], 1);
    chk("t4_overrun", bus.overrun, 1);
    chk("t4_idx", bus.bunch_idx, 2);
`ifdef SEQ_RUN_COUNT_EN
    chk("t6_count_2", run_count, 2);
`endif

    // Test 5: abort mid-run, then re-arm and complete
    cfg(10'd10, 5'd2, 8'd1, 11'd100);
    pulse_arm();
    pulse_trig();
    chk("t5_overrun_clr", bus.overrun, 0);
    capture(50);
    chk("t5_store_i50", bus.store_strb, 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("t5_abort_store", bus.store_strb, 0);
    chk("t5_abort_busy", bus.busy, 0);
    chk("t5_abort_bunch", bus.bunch_strb, 0);
    dcount = 0;
    for (int c = 0; c < 300; c++) begin
      if (bus.done === 1'b1) dcount++;
      step();
    end
    chk("t5_no_done", dcount, 0);
    pulse_arm();
    chk("t5_rearm_busy", bus.busy, 1);
    pulse_trig();
    capture(320);
    chk("t5_rerun_store", st_cnt, 300);
    chk("t5_rerun_bunch", bs_cnt, 2);
    chk("t5_rerun_done", dn_cnt, 1);
`ifdef SEQ_RUN_COUNT_EN
    chk("t6_count_3", run_count, 3);
`endif

    // Reset mid-run clears outputs asynchronously
    pulse_arm();
    pulse_trig();
    capture(20);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_store", bus.store_strb, 0);
    chk("rst_mid_busy", bus.busy, 0);
`ifdef SEQ_RUN_COUNT_EN
    chk("t6_count_rst", run_count, 0);
`endif
    step();
    rst = 1'b0;
    step();
    chk("rst_mid_done", bus.done, 0);
    pulse_trig();
    chk("rst_mid_idle_trig", bus.store_strb, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
